// File: rtl/cmp_seq.sv
// Sequential compare/branch-resolution unit: resolves EQ/NE/SLT/SLTU/LT/GE/LTU/GEU
// MSB-first, DIGIT bits per cycle. Define CMP_EARLY_EXIT_EN to stop at the first unequal chunk.
module cmp_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [WIDTH-1:0] out_word
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               lt_q, lt_d, eq_q, eq_d, dec_q, dec_d, flag_q, flag_d;

  logic [WIDTH-1:0]   sh_a, sh_b;
  logic [DIGIT-1:0]   chunk_a, chunk_b;
  logic               is_signed, res_lt, res_eq, res_dec, run_done, flag_res;

  // Offset-binary trick: flipping the sign bit of the top chunk turns a signed
  // compare into an unsigned one, so no subtraction or carry is ever needed.
  always_comb begin
    is_signed = (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b101);
    sh_a      = a_q >> (DIGIT * int'(idx_q));
    sh_b      = b_q >> (DIGIT * int'(idx_q));
    chunk_a   = sh_a[DIGIT-1:0];
    chunk_b   = sh_b[DIGIT-1:0];
    if (is_signed && (idx_q == IDX_W'(N - 1))) begin
      chunk_a[DIGIT-1] = ~chunk_a[DIGIT-1];
      chunk_b[DIGIT-1] = ~chunk_b[DIGIT-1];
    end
  end

  // Once decided, later chunks are ignored so the constant-time walk keeps the first result.
  always_comb begin
    res_lt  = lt_q;
    res_eq  = eq_q;
    res_dec = dec_q;
    if (!dec_q) begin
      if (chunk_a != chunk_b) begin
        res_lt  = (chunk_a < chunk_b);
        res_eq  = 1'b0;
        res_dec = 1'b1;
      end else if (idx_q == '0) begin
        res_lt  = 1'b0;
        res_eq  = 1'b1;
        res_dec = 1'b1;
      end
    end
`ifdef CMP_EARLY_EXIT_EN
    run_done = res_dec;
`else
    run_done = (idx_q == '0);
`endif
    case (op_q)
      3'b000:  flag_res = res_eq;
      3'b001:  flag_res = ~res_eq;
      3'b101,
      3'b111:  flag_res = ~res_lt;
      default: flag_res = res_lt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (run_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_flag  = flag_q;
    out_word  = {{(WIDTH-1){1'b0}}, flag_q};
  end

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    idx_d  = idx_q;
    lt_d   = lt_q;
    eq_d   = eq_q;
    dec_d  = dec_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d   = in_a;
        b_d   = in_b;
        op_d  = in_op;
        idx_d = IDX_W'(N - 1);
        lt_d  = 1'b0;
        eq_d  = 1'b0;
        dec_d = 1'b0;
      end
      RUN: begin
        lt_d  = res_lt;
        eq_d  = res_eq;
        dec_d = res_dec;
        if (run_done) flag_d = flag_res;
        else          idx_d  = idx_q - IDX_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx_q  <= IDX_W'(N - 1);
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      dec_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      idx_q  <= idx_d;
      lt_q   <= lt_d;
      eq_q   <= eq_d;
      dec_q  <= dec_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq: directed cases plus randomized requests against
// an arithmetic reference model (signed/unsigned compares, chunk-count latency).
module tb_cmp_seq;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  localparam logic [2:0] OP_EQ = 3'b000, OP_NE = 3'b001, OP_SLT = 3'b010, OP_SLTU = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100, OP_GE = 3'b101, OP_LTU = 3'b110, OP_GEU = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_flag;
  logic [W-1:0] in_a, in_b, out_word;
  logic [2:0]   in_op;

  int checks = 0;
  int errors = 0;

  cmp_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag), .out_word(out_word)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_flag(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit lt_s, lt_u, eq;
    lt_s = ($signed(a) < $signed(b));
    lt_u = (a < b);
    eq   = (a == b);
    case (op)
      OP_EQ:          return eq;
      OP_NE:          return !eq;
      OP_SLT, OP_LT:  return lt_s;
      OP_SLTU, OP_LTU: return lt_u;
      OP_GE:          return !lt_s;
      default:        return !lt_u;
    endcase
  endfunction

  // Edge at which out_valid rises: chunks examined until the first difference, or all N.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--)
      if (a[i*D +: D] != b[i*D +: D]) return N - i;
`endif
    return N;
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit exp_flag);
    int edges;
    check({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_op    = 3'($urandom);
    edges    = 0;
    do begin
      check({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      edges++;
    end while (!out_valid && edges < 2 * N + 4);
    check({tag, ":out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ":latency"}, 64'(edges), 64'(model_lat(a, b)));
    check({tag, ":flag"}, 64'(out_flag), 64'(exp_flag));
    check({tag, ":word"}, 64'(out_word), 64'({31'b0, exp_flag}));
    @(negedge clk);
    check({tag, ":valid_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, ":ready_after_hs"}, 64'(in_ready), 64'd1);
    check({tag, ":flag_held"}, 64'(out_flag), 64'(exp_flag));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    int           edges;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    @(negedge clk);
    check("rst:in_ready", 64'(in_ready), 64'd1);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:out_flag", 64'(out_flag), 64'd0);
    check("rst:out_word", 64'(out_word), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("slt_neg1_1",   OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b1);
    run("sltu_neg1_1",  OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run("eq_same",      OP_EQ,   32'h12345678, 32'h12345678, 1'b1);
    run("ne_same",      OP_NE,   32'h12345678, 32'h12345678, 1'b0);
    run("ge_min_max",   OP_GE,   32'h80000000, 32'h7FFFFFFF, 1'b0);
    run("ltu_min_max",  OP_LTU,  32'h80000000, 32'h7FFFFFFF, 1'b0);
    run("geu_min_max",  OP_GEU,  32'h80000000, 32'h7FFFFFFF, 1'b1);
    run("lt_min_max",   OP_LT,   32'h80000000, 32'h7FFFFFFF, 1'b1);
    run("geu_equal",    OP_GEU,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);

    // Backpressure: result must hold while out_ready is low; a stray request is ignored.
    in_valid = 1'b1; in_op = OP_LT; in_a = 32'h00000100; in_b = 32'h00000200; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!out_valid && edges < 2 * N + 4);
    check("bp:latency", 64'(edges), 64'(model_lat(32'h00000100, 32'h00000200)));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = OP_EQ; in_a = 32'h5; in_b = 32'h6;
      check("bp:out_valid_hold", 64'(out_valid), 64'd1);
      check("bp:out_flag_hold", 64'(out_flag), 64'd1);
      check("bp:in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    check("bp:out_word", 64'(out_word), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp:valid_after_hs", 64'(out_valid), 64'd0);
    check("bp:ready_after_hs", 64'(in_ready), 64'd1);
    for (int i = 0; i < N + 2; i++) begin
      check("bp:no_stray_accept", 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of RUN drops the pending request.
    in_valid = 1'b1; in_op = OP_LTU; in_a = 32'h00000001; in_b = 32'h00000002; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort:out_valid", 64'(out_valid), 64'd0);
    check("abort:in_ready", 64'(in_ready), 64'd1);
    check("abort:out_flag", 64'(out_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort:idle_no_result", 64'(out_valid), 64'd0);
    run("eq_zero_after_abort", OP_EQ, 32'h0, 32'h0, 1'b1);

    // Random requests; half share upper chunks so every latency value gets exercised.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'h1 << $urandom_range(0, W - 1));
        default: rb = ra ^ 32'h80000000;
      endcase
      run("random", rop, ra, rb, model_flag(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
